// File: rtl/score_keeper.sv
// Round-by-round score keeper: accepts judge results, tracks round/win/lose and reports the final winner.
// Optional macro DRAW_REPLAY_EN: a drawn round is replayed instead of counted.
module score_keeper #(
   parameter int MAX_ROUNDS = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start,
   input  logic       res_valid,
   input  logic [1:0] res,
   output logic       res_ready,
   input  logic       fin,
   output logic [3:0] round,
   output logic [3:0] win,
   output logic [3:0] lose,
   output logic       game_over,
   output logic [1:0] winner,
   output logic       err
);

   localparam logic [3:0] MAX_R = 4'(MAX_ROUNDS);

   localparam logic [1:0] CODE_ILLEGAL = 2'b00;
   localparam logic [1:0] CODE_DRAW    = 2'b01;
   localparam logic [1:0] CODE_P1      = 2'b10;
   localparam logic [1:0] CODE_P2      = 2'b11;

   typedef enum logic [1:0] {IDLE, PLAY, CHECK, DONE} state_t;

   state_t     state_q;
   logic [3:0] round_q, win_q, lose_q;
   logic [3:0] round_d, win_d, lose_d;
   logic       res_ready_q;
   logic       game_over_q;
   logic [1:0] winner_q;
   logic       err_q;
   logic       xfer;

   assign xfer = res_valid && res_ready_q;

   // Counter values that a transfer in PLAY would commit.
   always_comb begin
      round_d = round_q;
      win_d   = win_q;
      lose_d  = lose_q;
      case (res)
         CODE_P1: begin
            win_d   = win_q + 4'd1;
            round_d = round_q + 4'd1;
         end
         CODE_P2: begin
            lose_d  = lose_q + 4'd1;
            round_d = round_q + 4'd1;
         end
         CODE_DRAW: begin
`ifdef DRAW_REPLAY_EN
            round_d = round_q;
`else
            round_d = round_q + 4'd1;
`endif
         end
         default: begin
            round_d = round_q;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         round_q     <= 4'd0;
         win_q       <= 4'd0;
         lose_q      <= 4'd0;
         res_ready_q <= 1'b0;
         game_over_q <= 1'b0;
         winner_q    <= 2'b00;
         err_q       <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  state_q     <= PLAY;
                  round_q     <= 4'd0;
                  win_q       <= 4'd0;
                  lose_q      <= 4'd0;
                  res_ready_q <= 1'b1;
                  game_over_q <= 1'b0;
                  winner_q    <= 2'b00;
               end
            end
            PLAY: begin
               if (xfer) begin
                  if (res == CODE_ILLEGAL) begin
                     // Illegal code is consumed but scores nothing; keep accepting.
                     err_q <= 1'b1;
                  end else begin
                     state_q     <= CHECK;
                     res_ready_q <= 1'b0;
                     round_q     <= round_d;
                     win_q       <= win_d;
                     lose_q      <= lose_d;
                  end
               end
            end
            CHECK: begin
               if (fin || round_q == MAX_R) begin
                  state_q     <= DONE;
                  game_over_q <= 1'b1;
                  if (win_q > lose_q)
                     winner_q <= CODE_P1;
                  else if (lose_q > win_q)
                     winner_q <= CODE_P2;
                  else
                     winner_q <= CODE_DRAW;
               end else begin
                  state_q     <= PLAY;
                  res_ready_q <= 1'b1;
               end
            end
            default: begin
               state_q     <= IDLE;
               res_ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign res_ready = res_ready_q;
   assign round     = round_q;
   assign win       = win_q;
   assign lose      = lose_q;
   assign game_over = game_over_q;
   assign winner    = winner_q;
   assign err       = err_q;

endmodule
